alu_operand_stage: RTL and testbench



---
 rtl/alu_operand_stage.sv | 91 +++++++++
 tb/tb_alu_operand_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage: 32-entry register file feeding a one-entry output register.
// Define ALU_BYPASS_EN to forward a same-edge writeback into the captured operands.
module alu_operand_stage #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [AW-1:0]   in_rs1_addr,
   input  logic [AW-1:0]   in_rs2_addr,
   input  logic [AW-1:0]   in_rd_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rs1,
   output logic [XLEN-1:0] rs2,
   output logic [AW-1:0]   rd_addr,
   input  logic            wb_en,
   input  logic [AW-1:0]   wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [XLEN-1:0] rs1_q, rs1_d;
   logic [XLEN-1:0] rs2_q, rs2_d;
   logic [AW-1:0]   rd_q, rd_d;
   logic            valid_q, valid_d;
   logic            wb_live;
   logic            accept;
   logic [XLEN-1:0] rd1_val, rd2_val;

   assign wb_live  = wb_en && (wb_addr != '0);
   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      rd1_val = (in_rs1_addr == '0) ? '0 : regs_q[in_rs1_addr];
      rd2_val = (in_rs2_addr == '0) ? '0 : regs_q[in_rs2_addr];
`ifdef ALU_BYPASS_EN
      if (wb_live && (wb_addr == in_rs1_addr)) rd1_val = wb_data;
      if (wb_live && (wb_addr == in_rs2_addr)) rd2_val = wb_data;
`endif
   end

   always_comb begin
      regs_d = regs_q;
      if (wb_live) regs_d[wb_addr] = wb_data;
      regs_d[0] = '0;
   end

   // Operands are captured once per accept and never refreshed while stalled.
   always_comb begin
      rs1_d   = rs1_q;
      rs2_d   = rs2_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      if (accept) begin
         rs1_d   = rd1_val;
         rs2_d   = rd2_val;
         rd_d    = in_rd_addr;
         valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;
   assign rs1       = rs1_q;
   assign rs2       = rs2_q;
   assign rd_addr   = rd_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed bench for alu_operand_stage against a register-file model.
// Honours ALU_BYPASS_EN the same way the design build does.
module tb_alu_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rs1_addr;
   logic [4:0]  in_rs2_addr;
   logic [4:0]  in_rd_addr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  rd_addr;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   alu_operand_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs1_addr (in_rs1_addr),
      .in_rs2_addr (in_rs2_addr),
      .in_rd_addr  (in_rd_addr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .rs1         (rs1),
      .rs2         (rs2),
      .rd_addr     (rd_addr),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   bit primed = 0;

   logic [31:0] mregs [32];
   logic        e_valid;
   logic [31:0] e_rs1, e_rs2;
   logic [4:0]  e_rd;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a,
                                              input logic we,
                                              input logic [4:0] wa,
                                              input logic [31:0] wd);
      logic [31:0] v;
      v = (a == 5'd0) ? 32'd0 : mregs[a];
`ifdef ALU_BYPASS_EN
      if (we && wa != 5'd0 && wa == a) v = wd;
`endif
      return v;
   endfunction

   task automatic cycle(input logic rstn, input logic iv,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic ordy,
                        input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
      logic acc;
      @(negedge clk);
      rst_n = rstn; in_valid = iv; in_rs1_addr = a1; in_rs2_addr = a2;
      in_rd_addr = rd; out_ready = ordy; wb_en = we; wb_addr = wa;
      wb_data = wd;
      #1;
      if (primed) check("in_ready", {31'd0, in_ready}, {31'd0, !e_valid || ordy});
      @(posedge clk);
      if (!rstn) begin
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         e_valid = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;
         primed = 1;
      end else begin
         acc = iv && (!e_valid || ordy);
         if (acc) begin
            e_rs1 = model_read(a1, we, wa, wd);
            e_rs2 = model_read(a2, we, wa, wd);
            e_rd = rd;
            e_valid = 1;
         end else if (e_valid && ordy) begin
            e_valid = 0;
         end
         if (we && wa != 5'd0) mregs[wa] = wd;
      end
      #1;
      check("out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      check("rs1", rs1, e_rs1);
      check("rs2", rs2, e_rs2);
      check("rd_addr", {27'd0, rd_addr}, {27'd0, e_rd});
   endtask

   task automatic idle();
      cycle(1, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0; in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0;
      in_rd_addr = 0; out_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
      e_valid = 0; e_rs1 = 0; e_rs2 = 0; e_rd = 0;

      // reset then read
      cycle(0, 1, 5, 31, 9, 1, 1, 5, 32'h1111);
      cycle(0, 1, 5, 31, 9, 1, 1, 5, 32'h1111);
      cycle(1, 1, 5, 31, 9, 1, 0, 0, 0);
      check("rst_read_v", {31'd0, out_valid}, 32'd1);
      check("rst_read_rs1", rs1, 32'd0);
      check("rst_read_rs2", rs2, 32'd0);

      // write then read
      cycle(1, 0, 0, 0, 0, 1, 1, 3, 32'hFFFFFFFF);
      cycle(1, 1, 3, 0, 2, 1, 0, 0, 0);
      check("wr_rd_rs1", rs1, 32'hFFFFFFFF);
      check("wr_rd_rs2", rs2, 32'd0);

      // register 0 immunity
      cycle(1, 0, 0, 0, 0, 1, 1, 0, 32'h12345678);
      cycle(1, 1, 0, 0, 0, 1, 0, 0, 0);
      check("x0_rs1", rs1, 32'd0);
      check("x0_rs2", rs2, 32'd0);

      // same-edge writeback and read
      cycle(1, 1, 7, 7, 6, 1, 1, 7, 32'hDEADBEEF);
`ifdef ALU_BYPASS_EN
      check("byp_rs1", rs1, 32'hDEADBEEF);
      check("byp_rs2", rs2, 32'hDEADBEEF);
`else
      check("nobyp_rs1", rs1, 32'd0);
      check("nobyp_rs2", rs2, 32'd0);
`endif
      idle();

      // backpressure
      cycle(1, 0, 0, 0, 0, 1, 1, 1, 32'hAAAA0000);
      cycle(1, 1, 1, 0, 10, 0, 0, 0, 0);
      cycle(1, 1, 3, 3, 11, 0, 1, 1, 32'h5555);
      check("stall_rs1", rs1, 32'hAAAA0000);
      check("stall_rd", {27'd0, rd_addr}, 32'd10);
      cycle(1, 1, 1, 3, 12, 1, 0, 0, 0);
      check("b_rs1", rs1, 32'h5555);
      check("b_rd", {27'd0, rd_addr}, 32'd12);

      // full throughput
      for (int k = 1; k <= 4; k++) begin
         cycle(1, 1, 5'(k), 5'(k + 1), 5'(k), 1, 0, 0, 0);
         check("thru_v", {31'd0, out_valid}, 32'd1);
         check("thru_rd", {27'd0, rd_addr}, k);
      end
      idle();

      // reset mid-stall
      cycle(1, 1, 1, 1, 13, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 14, 0, 0, 0, 0);
      check("rst_stall_v", {31'd0, out_valid}, 32'd0);
      check("rst_stall_rs1", rs1, 32'd0);

      // random traffic with clustered addresses for hazards
      for (int n = 0; n < 600; n++) begin
         logic [4:0] a1, a2, wa;
         a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
         a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
         wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
         cycle(($urandom_range(0, 59) != 0), 1'($urandom), a1, a2,
               5'($urandom), 1'($urandom), 1'($urandom), wa, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
